// File: rtl/ethpipe_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ethpipe_regs_pkg
//  Purpose  : Shared word-index constants and byte-order helpers for the
//             ethpipe BAR0 register block.
//  Contents : top-level word indices, per-channel offsets, byte swap and
//             byte-lane merge functions.
//  Revision : 1.0  initial release
// ============================================================================
package ethpipe_regs_pkg;

   // Top-level word indices (word address = adr[6:1])
   localparam logic [5:0] W_VERSION = 6'h00;
   localparam logic [5:0] W_CTRL    = 6'h01;
   localparam logic [5:0] W_CNT0    = 6'h02;
   localparam logic [5:0] W_CNT1    = 6'h03;
   localparam logic [5:0] W_CNT2    = 6'h04;
   localparam logic [5:0] W_CNT3    = 6'h05;

   // Channel c occupies words CH_BASE + c*CH_STRIDE .. +7
   localparam logic [5:0] CH_BASE   = 6'h08;
   localparam logic [5:0] CH_STRIDE = 6'h08;

   // Offsets inside one channel's eight-word window
   localparam logic [2:0] CH_CTRL     = 3'd0;
   localparam logic [2:0] CH_FLAGS    = 3'd1;
   localparam logic [2:0] CH_START_LO = 3'd2;
   localparam logic [2:0] CH_START_HI = 3'd3;
   localparam logic [2:0] CH_END_LO   = 3'd4;
   localparam logic [2:0] CH_END_HI   = 3'd5;
   localparam logic [2:0] CH_CUR_LO   = 3'd6;
   localparam logic [2:0] CH_CUR_HI   = 3'd7;

   // Control word bit positions
   localparam int CTRL_CLEAR_BIT  = 0;
   localparam int CTRL_FREEZE_BIT = 1;

   // The bus carries register words in host byte order: bytes swapped.
   function automatic logic [15:0] byte_swap(input logic [15:0] v);
      return {v[7:0], v[15:8]};
   endfunction

   // Replace the enabled bytes of old_v with those of new_v.
   // be[0] enables bits 7:0, be[1] enables bits 15:8.
   function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                           input logic [15:0] new_v,
                                           input logic [1:0]  be);
      return {be[1] ? new_v[15:8] : old_v[15:8],
              be[0] ? new_v[7:0]  : old_v[7:0]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ethpipe_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : ethpipe_regs_if
//  Purpose  : pcie_tlp 16-bit slave bus seen by the BAR0 register block.
//  Signals  : slv_bar_hit_i  access targets BAR0
//             slv_ce_i       one-cycle access strobe
//             slv_we_i       1 = write, 0 = read
//             slv_adr_i      16-bit word address (byte address bits 11:1)
//             slv_dat_i      write data, host byte order
//             slv_sel_i      byte lane enables
//             slv_dat_o      registered read data
//  Modports : master (bus driver), slave (register block)
//  Revision : 1.0  initial release
// ============================================================================
interface ethpipe_regs_if;
   logic        slv_bar_hit_i;
   logic        slv_ce_i;
   logic        slv_we_i;
   logic [11:1] slv_adr_i;
   logic [15:0] slv_dat_i;
   logic [1:0]  slv_sel_i;
   logic [15:0] slv_dat_o;

   modport master (
      output slv_bar_hit_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i,
      input  slv_dat_o
   );

   modport slave (
      input  slv_bar_hit_i, slv_ce_i, slv_we_i, slv_adr_i, slv_dat_i, slv_sel_i,
      output slv_dat_o
   );
endinterface
`default_nettype wire

// File: rtl/ethpipe_regs_chan.sv
`default_nettype none
// ============================================================================
//  Module   : ethpipe_regs_chan
//  Purpose  : Register set of one receive DMA channel: ctrl, W1C event
//             flags, start/end window, current-pointer readback, and the
//             channel's contribution to the interrupt.
//  Ports    : clk, rst_n          clock, async active-low reset
//             wr_en               decoded write strobe for this channel
//             offset              word offset inside the channel window
//             wdata, be           write data in register byte order + lanes
//             addr_cur            current DMA pointer (address bits 31:2)
//             ev_wrap, ev_drop    one-cycle event pulses
//             dma_en              channel enable
//             addr_start/end      window bounds (address bits 31:2)
//             rdata               read value for 'offset', register order
//             irq_term            unregistered interrupt term
//  Revision : 1.0  initial release
// ============================================================================
module ethpipe_regs_chan
   import ethpipe_regs_pkg::*;
#(
   parameter logic [29:0] RST_START = 30'd0,
   parameter logic [29:0] RST_END   = 30'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [2:0]  offset,
   input  logic [15:0] wdata,
   input  logic [1:0]  be,
   input  logic [29:0] addr_cur,
   input  logic        ev_wrap,
   input  logic        ev_drop,
   output logic        dma_en,
   output logic [29:0] addr_start,
   output logic [29:0] addr_end,
   output logic [15:0] rdata,
   output logic        irq_term
);

   // ctrl[0] dma_en, ctrl[1] irq_en_wrap, ctrl[2] irq_en_drop
   logic [2:0] ctrl;
   // flags[0] wrap, flags[1] drop
   logic [1:0] flags;
   logic [1:0] flags_clr;

   assign dma_en   = ctrl[0];
   assign irq_term = (flags[0] & ctrl[1]) | (flags[1] & ctrl[2]);

   // Flag bits live in the low byte, so only that lane can clear them.
   assign flags_clr = (wr_en && offset == CH_FLAGS && be[0]) ? wdata[1:0] : 2'b00;

   // Set is applied after clear so a same-cycle event wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags <= 2'b00;
      end else begin
         flags <= (flags & ~flags_clr) | {ev_drop, ev_wrap};
      end
   end

   // Address words: the low word holds bits 15:2 in its upper 14 bits, so
   // its low byte maps to addr[5:0] (bits 1:0 of the byte are discarded).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl       <= 3'b000;
         addr_start <= RST_START;
         addr_end   <= RST_END;
      end else begin
         if (wr_en && be[0]) begin
            case (offset)
               CH_CTRL:     ctrl              <= wdata[2:0];
               CH_START_LO: addr_start[5:0]   <= wdata[7:2];
               CH_START_HI: addr_start[21:14] <= wdata[7:0];
               CH_END_LO:   addr_end[5:0]     <= wdata[7:2];
               CH_END_HI:   addr_end[21:14]   <= wdata[7:0];
               default: ;
            endcase
         end
         if (wr_en && be[1]) begin
            case (offset)
               CH_START_LO: addr_start[13:6]  <= wdata[15:8];
               CH_START_HI: addr_start[29:22] <= wdata[15:8];
               CH_END_LO:   addr_end[13:6]    <= wdata[15:8];
               CH_END_HI:   addr_end[29:22]   <= wdata[15:8];
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      rdata = 16'h0000;
      case (offset)
         CH_CTRL:     rdata = {13'd0, ctrl};
         CH_FLAGS:    rdata = {14'd0, flags};
         CH_START_LO: rdata = {addr_start[13:0], 2'b00};
         CH_START_HI: rdata = addr_start[29:14];
         CH_END_LO:   rdata = {addr_end[13:0], 2'b00};
         CH_END_HI:   rdata = addr_end[29:14];
         CH_CUR_LO:   rdata = {addr_cur[13:0], 2'b00};
         CH_CUR_HI:   rdata = addr_cur[29:14];
         default:     rdata = 16'h0000;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/ethpipe_regs.sv
`default_nettype none
// ============================================================================
//  Module   : ethpipe_regs
//  Purpose  : BAR0 control/status register block for the ethpipe PCIe
//             datapath: version word, 64-bit free-running counter with
//             snapshot readout, NCH DMA channel register sets and a
//             registered, maskable interrupt.
//  Ports    : clk_125, sys_rst_n   clock, async active-low reset
//             slv                  pcie_tlp slave bus (slave modport)
//             dma_en_o             per-channel enable
//             dma_addr_start_o     packed, channel c at [30c+29:30c]
//             dma_addr_end_o       packed, same layout
//             dma_addr_cur_i       packed current pointers from the engines
//             ev_wrap_i, ev_drop_i per-channel event pulses
//             global_counter_o     live counter
//             irq_o                registered interrupt request
//  Revision : 1.0  initial release
// ============================================================================
module ethpipe_regs
   import ethpipe_regs_pkg::*;
#(
   parameter int          NCH      = 2,
   parameter logic [15:0] VERSION  = 16'h0201,
   parameter logic [31:0] DMA_BASE = 32'h1000_0000,
   parameter logic [31:0] DMA_SLOT = 32'h0001_0000
) (
   input  logic               clk_125,
   input  logic               sys_rst_n,
   ethpipe_regs_if.slave      slv,
   output logic [NCH-1:0]     dma_en_o,
   output logic [NCH*30-1:0]  dma_addr_start_o,
   output logic [NCH*30-1:0]  dma_addr_end_o,
   input  logic [NCH*30-1:0]  dma_addr_cur_i,
   input  logic [NCH-1:0]     ev_wrap_i,
   input  logic [NCH-1:0]     ev_drop_i,
   output logic [63:0]        global_counter_o,
   output logic               irq_o
);

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic        hit;
   logic        wr;
   logic        rd;
   logic [5:0]  word;
   logic [15:0] wv;        // write data in register byte order
   logic [1:0]  be;        // lane enables in register byte order

   assign hit  = slv.slv_bar_hit_i & slv.slv_ce_i & (slv.slv_adr_i[11:7] == 5'd0);
   assign wr   = hit & slv.slv_we_i;
   assign rd   = hit & ~slv.slv_we_i;
   assign word = slv.slv_adr_i[6:1];
   assign wv   = byte_swap(slv.slv_dat_i);
   // sel[1] carries the register's low byte, sel[0] its high byte
   assign be   = {slv.slv_sel_i[0], slv.slv_sel_i[1]};

   // ------------------------------------------------------------------
   // Global counter, freeze and snapshot
   // ------------------------------------------------------------------
   logic [63:0] counter;
   logic [63:0] cnt_written;
   logic [47:0] snapshot;
   logic        freeze;
   logic        ctrl_wr;
   logic        clear_req;
   logic        cnt_wr;

   assign ctrl_wr   = wr & (word == W_CTRL);
   assign clear_req = ctrl_wr & be[0] & wv[CTRL_CLEAR_BIT];
   assign cnt_wr    = wr & (word >= W_CNT0) & (word <= W_CNT3);

   always_comb begin
      cnt_written = counter;
      case (word)
         W_CNT0:  cnt_written[15:0]  = merge16(counter[15:0],  wv, be);
         W_CNT1:  cnt_written[31:16] = merge16(counter[31:16], wv, be);
         W_CNT2:  cnt_written[47:32] = merge16(counter[47:32], wv, be);
         W_CNT3:  cnt_written[63:48] = merge16(counter[63:48], wv, be);
         default: ;
      endcase
   end

   // Clear has priority over a slice write, which replaces that cycle's
   // increment; the counter wraps through zero naturally.
   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         counter <= 64'd0;
      end else if (clear_req) begin
         counter <= 64'd0;
      end else if (cnt_wr) begin
         counter <= cnt_written;
      end else if (!freeze) begin
         counter <= counter + 64'd1;
      end
   end

   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         freeze <= 1'b0;
      end else if (ctrl_wr && be[0]) begin
         freeze <= wv[CTRL_FREEZE_BIT];
      end
   end

   // Reading the low word captures the upper 48 bits on the same edge, so
   // the following reads of the upper words see one coherent value.
   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         snapshot <= 48'd0;
      end else if (rd && word == W_CNT0) begin
         snapshot <= counter[63:16];
      end
   end

   assign global_counter_o = counter;

   // ------------------------------------------------------------------
   // Channels
   // ------------------------------------------------------------------
   logic [15:0]    chan_rdata [NCH];
   logic [NCH-1:0] irq_terms;

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      localparam logic [31:0] START_C = DMA_BASE + DMA_SLOT * 32'(c);
      localparam logic [31:0] END_C   = START_C + DMA_SLOT;

      logic chan_wr;
      assign chan_wr = wr & (word[5:3] == 3'(c + 1));

      ethpipe_regs_chan #(
         .RST_START (START_C[31:2]),
         .RST_END   (END_C[31:2])
      ) u_chan (
         .clk        (clk_125),
         .rst_n      (sys_rst_n),
         .wr_en      (chan_wr),
         .offset     (word[2:0]),
         .wdata      (wv),
         .be         (be),
         .addr_cur   (dma_addr_cur_i[30*c +: 30]),
         .ev_wrap    (ev_wrap_i[c]),
         .ev_drop    (ev_drop_i[c]),
         .dma_en     (dma_en_o[c]),
         .addr_start (dma_addr_start_o[30*c +: 30]),
         .addr_end   (dma_addr_end_o[30*c +: 30]),
         .rdata      (chan_rdata[c]),
         .irq_term   (irq_terms[c])
      );
   end

   // ------------------------------------------------------------------
   // Read mux and registered read data
   // ------------------------------------------------------------------
   logic [15:0] rd_val;
   logic [15:0] dat_q;

   always_comb begin
      rd_val = 16'h0000;
      case (word)
         W_VERSION: rd_val = VERSION;
         W_CTRL:    rd_val = {14'd0, freeze, 1'b0};
         W_CNT0:    rd_val = counter[15:0];
         W_CNT1:    rd_val = snapshot[15:0];
         W_CNT2:    rd_val = snapshot[31:16];
         W_CNT3:    rd_val = snapshot[47:32];
         default: begin
            // Words 0x06/0x07 and channel windows at or beyond NCH match
            // nothing here and read zero.
            for (int c = 0; c < NCH; c++) begin
               if (word[5:3] == 3'(c + 1)) begin
                  rd_val = chan_rdata[c];
               end
            end
         end
      endcase
   end

   // Every read strobe updates the data register; reads outside BAR0 or
   // outside the decoded window return zero.
   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         dat_q <= 16'h0000;
      end else if (slv.slv_ce_i && !slv.slv_we_i) begin
         dat_q <= rd ? byte_swap(rd_val) : 16'h0000;
      end
   end

   assign slv.slv_dat_o = dat_q;

   // ------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------
   always_ff @(posedge clk_125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= |irq_terms;
      end
   end

endmodule
`default_nettype wire
